// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, default frame
// length, FSM state encoding and a helper that sizes the baud tick counter.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int DEFAULT_FRAME_TICKS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SEND   = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Counter must hold the larger of the two terminal counts without wrapping.
    function automatic int cnt_width(input int frame_ticks, input int gap_ticks);
        int max_ticks;
        max_ticks = (frame_ticks > gap_ticks) ? frame_ticks : gap_ticks;
        return (max_ticks < 1) ? 1 : $clog2(max_ticks + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer / transmitter side bundle of the UART transmit arbiter.
//
// Handshake: a byte moves from requester i when req_valid[i] and req_ready[i]
// are both high on a rising clk edge. A requester that raises valid keeps
// valid high and its data byte stable until it sees ready; dropping valid
// without a transfer is allowed and simply withdraws the request.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*UART_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx_start;
    logic [UART_DATA_W-1:0]         tx_data;
    logic                           busy;
    logic [ID_W-1:0]                grant_id;
    state_t                         dbg_state;

    // Arbiter side
    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output tx_start,
        output tx_data,
        output busy,
        output grant_id,
        output dbg_state
    );

    // Producer / observer side
    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  tx_start,
        input  tx_data,
        input  busy,
        input  grant_id,
        input  dbg_state
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant to the first requester at or
// after ptr, searching upward with wrap. All zeros when nothing is requesting.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Walk the rotation distance k outward from ptr; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers. A byte accepted in IDLE is presented with tx_start until the
// transmitter's first baud tick; baud ticks are then counted through the frame
// and an optional inter-frame gap so that no new start is issued mid-frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = DEFAULT_FRAME_TICKS,
    parameter int GAP_TICKS   = 1
) (
    input logic              clk,
    input logic              reset,
    input logic              baud_tick,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(FRAME_TICKS, GAP_TICKS);

    // The launch tick is tick 1 of the frame, so the counter holds the number
    // of frame ticks already seen; the frame ends on the tick that would take
    // it to FRAME_TICKS. In GAP the counter starts at 0 and the GAP_TICKS-th
    // tick is the one seen while it equals GAP_TICKS-1.
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam state_t           FRAME_NEXT = (GAP_TICKS == 0) ? IDLE : GAP;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]        grant_q, grant_d;

    logic [NUM_REQ-1:0]     pick;
    logic [NUM_REQ-1:0]     ready;
    logic [ID_W-1:0]        pick_id;
    logic [UART_DATA_W-1:0] pick_byte;
    logic                   handshake;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (pick)
    );

    // Encode the one-hot pick and select the matching requester's byte.
    always_comb begin
        pick_id   = '0;
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_id   = ID_W'(i);
                pick_byte = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    // Ready only in IDLE and never while reset is held, so nothing is offered
    // during reset even though the FSM already sits in IDLE.
    always_comb begin
        ready     = '0;
        handshake = 1'b0;
        if (state_q == IDLE && reset) begin
            ready = pick;
        end
        handshake = |(bus.req_valid & ready);
    end

    // Next-state logic: accept, launch, count frame ticks, count gap ticks.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                // Ticks arriving here are ignored; counting starts in LAUNCH.
                if (handshake) begin
                    data_d  = pick_byte;
                    grant_d = pick_id;
                    ptr_d   = (pick_id == LAST_ID) ? '0 : pick_id + ID_W'(1);
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (baud_tick) begin
                    if (FRAME_TICKS <= 1) begin
                        cnt_d   = '0;
                        state_d = FRAME_NEXT;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (baud_tick) begin
                    if (cnt_q == FRAME_LAST) begin
                        cnt_d   = '0;
                        state_d = FRAME_NEXT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            GAP: begin
                if (baud_tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_start  = (state_q == LAUNCH);
    assign bus.tx_data   = data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = grant_q;
    assign bus.dbg_state = state_q;

endmodule
